// File: rtl/npn_sweep_pkg.sv
// Shared types, constants and helpers for the NPN truth-table sweeper.
package npn_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    EVAL  = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam int unsigned NMINTERM = 16;
  localparam int unsigned PERM_W   = 8;

  // Four 2-bit fields form a bijection exactly when every value 0..3 appears.
  function automatic logic perm_is_bijective(input logic [PERM_W-1:0] p);
    logic [3:0] seen;
    seen = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      seen[p[2*i +: 2]] = 1'b1;
    end
    return &seen;
  endfunction

endpackage

// File: rtl/npn_input_xform.sv
// Combinational input side of the NPN transform: permute minterm bits, then negate.
module npn_input_xform
  import npn_sweep_pkg::*;
(
  input  logic [3:0]        i_m,
  input  logic [PERM_W-1:0] i_perm,
  input  logic [3:0]        i_neg_mask,
  output logic [3:0]        o_x
);

  // Netlist input i takes minterm bit perm_i, optionally inverted.
  always_comb begin
    o_x = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      o_x[i] = i_m[i_perm[2*i +: 2]] ^ i_neg_mask[i];
    end
  end

endmodule

// File: rtl/npn_tt_sweeper.sv
// Sweeps a 4-input netlist over all minterms through an NPN transform and
// captures/compares the resulting truth table.
module npn_tt_sweeper
  import npn_sweep_pkg::*;
#(
  parameter int unsigned SETTLE = 1,
  parameter int unsigned NIN    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  perm,
  input  logic [3:0]  neg_mask,
  input  logic        out_neg,
  input  logic [15:0] exp_tt,
  output logic [3:0]  dut_x,
  input  logic        dut_y,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt,
  output logic        match,
  output logic        perm_err
);

  if (NIN != 4) begin : g_nin_check
    $error("npn_tt_sweeper: NIN must be 4");
  end
  if (SETTLE > 7) begin : g_settle_check
    $error("npn_tt_sweeper: SETTLE must be 0..7");
  end

  localparam logic [2:0] SETTLE_C = 3'(SETTLE);
  localparam logic [3:0] M_LAST   = 4'(NMINTERM - 1);

  state_t      r_state, w_state_next;
  logic [3:0]  r_m, w_m_next;
  logic [2:0]  r_c;
  logic [7:0]  r_perm;
  logic [3:0]  r_neg;
  logic        r_out_neg;
  logic [15:0] r_exp;
  logic [15:0] r_tt, w_tt_upd;
  logic [3:0]  r_dut_x, w_x_next;
  logic        r_match, r_perm_err;
  logic        w_sample, w_capture, w_perm_ok;

  assign w_perm_ok = perm_is_bijective(r_perm);
  assign w_sample  = (r_state == EVAL) && (r_c == SETTLE_C);
  assign w_capture = w_sample && !abort;

  // The transform sees the minterm of the *next* cycle so dut_x is registered
  // on the same edge that advances m.
  npn_input_xform u_xform (
    .i_m        (w_m_next),
    .i_perm     (r_perm),
    .i_neg_mask (r_neg),
    .o_x        (w_x_next)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state and next-minterm selection.
  always_comb begin
    w_state_next = r_state;
    w_m_next     = r_m;
    case (r_state)
      IDLE:  if (start && !abort) w_state_next = CHECK;
      CHECK: begin
        if (abort)           w_state_next = IDLE;
        else if (!w_perm_ok) w_state_next = FIN;
        else begin
          w_state_next = EVAL;
          w_m_next     = '0;
        end
      end
      EVAL: begin
        if (abort) w_state_next = IDLE;
        else if (w_sample) begin
          if (r_m == M_LAST) w_state_next = FIN;
          else               w_m_next     = r_m + 4'd1;
        end
      end
      FIN:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Truth table with the current sample merged in, so match on entry to FIN
  // already reflects the final minterm.
  always_comb begin
    w_tt_upd = r_tt;
    if (w_capture) w_tt_upd[r_m] = dut_y ^ r_out_neg;
  end

  // Configuration latch, counters, capture and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m        <= '0;
      r_c        <= '0;
      r_perm     <= '0;
      r_neg      <= '0;
      r_out_neg  <= 1'b0;
      r_exp      <= '0;
      r_tt       <= '0;
      r_dut_x    <= '0;
      r_match    <= 1'b0;
      r_perm_err <= 1'b0;
    end else begin
      if (r_state == IDLE && w_state_next == CHECK) begin
        r_perm     <= perm;
        r_neg      <= neg_mask;
        r_out_neg  <= out_neg;
        r_exp      <= exp_tt;
        r_tt       <= '0;
        r_match    <= 1'b0;
        r_perm_err <= 1'b0;
      end
      if (r_state == CHECK && w_state_next == FIN) r_perm_err <= 1'b1;
      r_m <= w_m_next;
      if (r_state == CHECK)     r_c <= '0;
      else if (r_state == EVAL) r_c <= w_sample ? 3'd0 : r_c + 3'd1;
      if (w_capture) r_tt <= w_tt_upd;
      if (w_state_next == FIN && r_state != FIN)
        r_match <= (w_tt_upd == r_exp) && w_perm_ok;
      r_dut_x <= (w_state_next == EVAL) ? w_x_next : 4'd0;
    end
  end

  assign dut_x    = r_dut_x;
  assign busy     = (r_state == CHECK) || (r_state == EVAL);
  assign done     = (r_state == FIN);
  assign tt       = r_tt;
  assign match    = r_match;
  assign perm_err = r_perm_err;

endmodule

// File: tb/tb_npn_tt_sweeper.sv
// Bench for npn_tt_sweeper: SETTLE=1 instance (u1) driven from a vector table,
// SETTLE=2 instance (u2) driven by hand-written timing/control sequences.
module tb_npn_tt_sweeper;

  logic              clk;
  logic              rst_n;
  logic [1:0]        start;
  logic              abort;
  logic [7:0]        perm;
  logic [3:0]        neg_mask;
  logic              out_neg;
  logic [15:0]       exp_tt;
  logic              net_sel;   // 0: AND4, 1: y = x0
  logic [1:0][3:0]   dut_x;
  logic [1:0]        dut_y;
  logic [1:0]        busy, done, match, perm_err;
  logic [1:0][15:0]  tt;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  npn_tt_sweeper #(.SETTLE(1), .NIN(4)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort), .perm(perm),
    .neg_mask(neg_mask), .out_neg(out_neg), .exp_tt(exp_tt), .dut_x(dut_x[0]),
    .dut_y(dut_y[0]), .busy(busy[0]), .done(done[0]), .tt(tt[0]),
    .match(match[0]), .perm_err(perm_err[0])
  );

  npn_tt_sweeper #(.SETTLE(2), .NIN(4)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort), .perm(perm),
    .neg_mask(neg_mask), .out_neg(out_neg), .exp_tt(exp_tt), .dut_x(dut_x[1]),
    .dut_y(dut_y[1]), .busy(busy[1]), .done(done[1]), .tt(tt[1]),
    .match(match[1]), .perm_err(perm_err[1])
  );

  assign dut_y[0] = net_sel ? dut_x[0][0] : &dut_x[0];
  assign dut_y[1] = net_sel ? dut_x[1][0] : &dut_x[1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] nm, input logic on,
                     input logic net, input logic [15:0] e);
    perm = p; neg_mask = nm; out_neg = on; net_sel = net; exp_tt = e;
  endtask

  // One full sweep on instance u; latency counted in edges after the accept edge.
  task automatic run_sweep(input int unsigned u, input string tag,
                           input logic [15:0] e_tt, input logic e_match,
                           input logic e_perr, input int unsigned e_lat,
                           input int unsigned pulse_at, input logic abort_fin);
    int unsigned n;
    logic got, moved;
    n = 0; got = 1'b0; moved = 1'b0;
    @(negedge clk); start[u] = 1'b1;
    @(posedge clk); #1 start[u] = 1'b0;
    chk({tag, " busy after accept"}, 32'(busy[u]), 32'd1);
    while (n < 400 && !got) begin
      @(posedge clk); n++; #1;
      if (dut_x[u] != 4'd0) moved = 1'b1;
      if (done[u]) got = 1'b1;
      else start[u] = (n == pulse_at);
    end
    start[u] = 1'b0;
    chk({tag, " done latency"}, n, e_lat);
    chk({tag, " tt"}, 32'(tt[u]), 32'(e_tt));
    chk({tag, " match"}, 32'(match[u]), 32'(e_match));
    chk({tag, " perm_err"}, 32'(perm_err[u]), 32'(e_perr));
    chk({tag, " busy at done"}, 32'(busy[u]), 32'd0);
    if (e_perr) chk({tag, " dut_x stayed 0"}, 32'(moved), 32'd0);
    if (abort_fin) abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk({tag, " done single cycle"}, 32'(done[u]), 32'd0);
    chk({tag, " busy idle"}, 32'(busy[u]), 32'd0);
    chk({tag, " tt held"}, 32'(tt[u]), 32'(e_tt));
    chk({tag, " match held"}, 32'(match[u]), 32'(e_match));
    chk({tag, " dut_x idle"}, 32'(dut_x[u]), 32'd0);
  endtask

  // Bounded wait until instance u drives dut_x == v.
  task automatic wait_x(input int unsigned u, input logic [3:0] v, input string tag);
    int unsigned n;
    n = 0;
    while (n < 200 && dut_x[u] != v) begin
      @(posedge clk); #1 n++;
    end
    chk({tag, " reached dut_x"}, 32'(dut_x[u]), 32'(v));
  endtask

  typedef struct {
    string       name;
    logic [7:0]  perm;
    logic [3:0]  neg;
    logic        on;
    logic        net;
    logic [15:0] exp_tt;
    logic [15:0] tt;
    logic        match;
    logic        perr;
    int unsigned lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    // SETTLE=1: done 1 + 16*2 = 33 edges after the accept edge (cycle k+34).
    vecs[0] = '{"ident_and4",  8'hE4, 4'h0, 1'b0, 1'b0, 16'h8000, 16'h8000, 1'b1, 1'b0, 33};
    vecs[1] = '{"neg_and4",    8'hE4, 4'hF, 1'b0, 1'b0, 16'h8000, 16'h0001, 1'b0, 1'b0, 33};
    vecs[2] = '{"perm_outneg", 8'h1B, 4'h0, 1'b1, 1'b1, 16'h00FF, 16'h00FF, 1'b1, 1'b0, 33};
    vecs[3] = '{"bad_perm",    8'hE0, 4'h0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1};
    vecs[4] = '{"ident_x0_on", 8'hE4, 4'h0, 1'b1, 1'b1, 16'h5555, 16'h5555, 1'b1, 1'b0, 33};
    vecs[5] = '{"perm4e_x0",   8'h4E, 4'h0, 1'b0, 1'b1, 16'hF0F0, 16'hF0F0, 1'b1, 1'b0, 33};

    rst_n = 1'b0; start = '0; abort = 1'b0;
    cfg(8'hE4, 4'h0, 1'b0, 1'b0, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("reset u%0d dut_x", u), 32'(dut_x[u]), 32'd0);
      chk($sformatf("reset u%0d busy/done/match/perr", u),
          {28'd0, busy[u], done[u], match[u], perm_err[u]}, 32'd0);
      chk($sformatf("reset u%0d tt", u), 32'(tt[u]), 32'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 6; i++) begin
      cfg(vecs[i].perm, vecs[i].neg, vecs[i].on, vecs[i].net, vecs[i].exp_tt);
      run_sweep(0, vecs[i].name, vecs[i].tt, vecs[i].match, vecs[i].perr,
                vecs[i].lat, 0, 1'b0);
    end

    // SETTLE=2: done 1 + 16*3 = 49 edges after accept (cycle k+50); start
    // pulsed mid-EVAL is ignored; abort while in FIN changes nothing.
    cfg(8'hE4, 4'h0, 1'b0, 1'b0, 16'h8000);
    run_sweep(1, "s2_full", 16'h8000, 1'b1, 1'b0, 49, 10, 1'b1);

    // start and abort together in IDLE: abort wins.
    @(negedge clk); start[1] = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start[1] = 1'b0; abort = 1'b0;
    chk("start+abort idle busy", 32'(busy[1]), 32'd0);
    @(posedge clk); #1;
    chk("start+abort idle dut_x", 32'(dut_x[1]), 32'd0);

    // Abort at m=5: y = x0 with identity perm, so tt holds bits 1 and 3 only.
    cfg(8'hE4, 4'h0, 1'b0, 1'b1, 16'h0000);
    @(negedge clk); start[1] = 1'b1;
    @(posedge clk); #1 start[1] = 1'b0;
    wait_x(1, 4'd5, "abort_m5");
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("abort busy", 32'(busy[1]), 32'd0);
    chk("abort dut_x", 32'(dut_x[1]), 32'd0);
    chk("abort partial tt", 32'(tt[1]), 32'h000A);
    chk("abort match", 32'(match[1]), 32'd0);
    begin
      logic saw_done;
      saw_done = 1'b0;
      repeat (60) begin
        @(posedge clk); #1;
        if (done[1] || busy[1]) saw_done = 1'b1;
      end
      chk("abort no done", 32'(saw_done), 32'd0);
    end

    // Asynchronous reset mid-EVAL, then a full sweep after release.
    @(negedge clk); start[1] = 1'b1;
    @(posedge clk); #1 start[1] = 1'b0;
    wait_x(1, 4'd7, "areset");
    chk("areset pre tt", 32'(tt[1]), 32'h002A);
    @(negedge clk); #1 rst_n = 1'b0;
    #1;
    chk("areset busy", 32'(busy[1]), 32'd0);
    chk("areset dut_x", 32'(dut_x[1]), 32'd0);
    chk("areset tt", 32'(tt[1]), 32'd0);
    chk("areset done/match/perr", {29'd0, done[1], match[1], perm_err[1]}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk);
    cfg(8'hE4, 4'h0, 1'b0, 1'b0, 16'h8000);
    run_sweep(1, "post_reset", 16'h8000, 1'b1, 1'b0, 49, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
